// File: rtl/prv664_sb_pkg.sv
// rtl/prv664_sb_pkg.sv - shared types and constants for the register scoreboard
package prv664_sb_pkg;

  localparam int SB_NREG  = 32;
  localparam int SB_IDLEN = 8;

  typedef logic [$clog2(SB_NREG)-1:0] sb_idx_t;
  typedef logic [SB_IDLEN-1:0]        itag_t;

  localparam string RNM_ENABLE = "ENABLE";

endpackage

// File: rtl/prv664_gscoreboard_cell.sv
// rtl/prv664_gscoreboard_cell.sv - one register's busy bit and pending itag
module prv664_gscoreboard_cell
  import prv664_sb_pkg::*;
#(
  parameter int NDISP    = 2,
  parameter int NCMT     = 2,
  parameter int IDLEN    = 8,
  parameter bit RNM_EN   = 1'b1,
  parameter bit TIE_ZERO = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   flush_i,
  input  logic [NDISP-1:0]       disp_hit_i,
  input  logic [NDISP*IDLEN-1:0] disp_itag_i,
  input  logic [NCMT-1:0]        cmt_hit_i,
  input  logic [NCMT*IDLEN-1:0]  cmt_itag_i,
  output logic                   busy_o,
  output logic                   busy_nxt_o,
  output logic [IDLEN-1:0]       pitag_o,
  output logic                   clr_now_o
);

  logic             busy_q, busy_d;
  logic [IDLEN-1:0] pitag_q, pitag_d;
  logic             clr_now;

  // With renaming on, only the writer we are waiting for may release the register
  always_comb begin
    clr_now = 1'b0;
    for (int k = 0; k < NCMT; k++) begin
      if (cmt_hit_i[k] && (!RNM_EN || (cmt_itag_i[k*IDLEN +: IDLEN] == pitag_q))) begin
        clr_now = 1'b1;
      end
    end
    if (TIE_ZERO) clr_now = 1'b0;
  end

  always_comb begin
    busy_d  = busy_q;
    pitag_d = pitag_q;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (|disp_hit_i) begin
      busy_d = 1'b1;
      // ascending scan so the youngest matching slot lands last
      for (int k = 0; k < NDISP; k++) begin
        if (disp_hit_i[k]) pitag_d = disp_itag_i[k*IDLEN +: IDLEN];
      end
    end else if (clr_now) begin
      busy_d = 1'b0;
    end
    if (TIE_ZERO) begin
      busy_d  = 1'b0;
      pitag_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      busy_q  <= 1'b0;
      pitag_q <= '0;
    end else begin
      busy_q  <= busy_d;
      pitag_q <= pitag_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_nxt_o = busy_d;
  assign pitag_o    = pitag_q;
  assign clr_now_o  = clr_now;

endmodule

// File: rtl/prv664_gscoreboard.sv
// rtl/prv664_gscoreboard.sv - parametrised register scoreboard with flush, bypassed reads and busy count
module prv664_gscoreboard
  import prv664_sb_pkg::*;
#(
  parameter int    NREG    = 32,
  parameter int    NDISP   = 2,
  parameter int    NCMT    = 2,
  parameter int    NRD     = 4,
  parameter int    IDLEN   = 8,
  parameter string RNM     = "ENABLE",
  parameter int    ZERO_HW = 1
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic                            flush_i,
  input  logic [NDISP-1:0]                disp_valid_i,
  input  logic [NDISP*$clog2(NREG)-1:0]   disp_rdindex_i,
  input  logic [NDISP*IDLEN-1:0]          disp_itag_i,
  input  logic [NCMT-1:0]                 cmt_valid_i,
  input  logic [NCMT-1:0]                 cmt_wren_i,
  input  logic [NCMT*$clog2(NREG)-1:0]    cmt_rdindex_i,
  input  logic [NCMT*IDLEN-1:0]           cmt_itag_i,
  input  logic [NRD*$clog2(NREG)-1:0]     rd_index_i,
  output logic [NRD-1:0]                  rd_busy_o,
  output logic [NRD*IDLEN-1:0]            rd_itag_o,
  output logic [NREG-1:0]                 busy_flag_o,
  output logic [NREG*IDLEN-1:0]           id_flag_o,
  output logic [$clog2(NREG):0]           busy_cnt_o
);

  localparam int IW = $clog2(NREG);
  localparam int CW = IW + 1;
  localparam bit RNM_EN = (RNM == RNM_ENABLE);

  logic [NREG-1:0]       busy, busy_nxt, clr_now;
  logic [NREG*IDLEN-1:0] pitag;
  logic [NDISP-1:0]      dhit [NREG];
  logic [NCMT-1:0]       chit [NREG];
  logic [CW-1:0]         busy_cnt_q, busy_cnt_d;

  always_comb begin
    dhit = '{default: '0};
    chit = '{default: '0};
    for (int g = 0; g < NREG; g++) begin
      for (int k = 0; k < NDISP; k++) begin
        dhit[g][k] = disp_valid_i[k] && (disp_rdindex_i[k*IW +: IW] == IW'(g));
      end
      for (int k = 0; k < NCMT; k++) begin
        chit[g][k] = cmt_valid_i[k] && cmt_wren_i[k] && (cmt_rdindex_i[k*IW +: IW] == IW'(g));
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cell
    prv664_gscoreboard_cell #(
      .NDISP    (NDISP),
      .NCMT     (NCMT),
      .IDLEN    (IDLEN),
      .RNM_EN   (RNM_EN),
      .TIE_ZERO ((ZERO_HW != 0) && (g == 0))
    ) u_cell (
      .clk_i       (clk_i),
      .arst_i      (arst_i),
      .flush_i     (flush_i),
      .disp_hit_i  (dhit[g]),
      .disp_itag_i (disp_itag_i),
      .cmt_hit_i   (chit[g]),
      .cmt_itag_i  (cmt_itag_i),
      .busy_o      (busy[g]),
      .busy_nxt_o  (busy_nxt[g]),
      .pitag_o     (pitag[g*IDLEN +: IDLEN]),
      .clr_now_o   (clr_now[g])
    );
  end

  // Counting the next-state vector keeps the count aligned with busy_flag_o
  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt_d = busy_cnt_d + CW'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) busy_cnt_q <= '0;
    else        busy_cnt_q <= busy_cnt_d;
  end

  always_comb begin
    rd_busy_o = '0;
    rd_itag_o = '0;
    for (int r = 0; r < NRD; r++) begin
      rd_busy_o[r] = busy[rd_index_i[r*IW +: IW]] & ~clr_now[rd_index_i[r*IW +: IW]];
      rd_itag_o[r*IDLEN +: IDLEN] = pitag[rd_index_i[r*IW +: IW]*IDLEN +: IDLEN];
    end
  end

  assign busy_flag_o = busy;
  assign id_flag_o   = pitag;
  assign busy_cnt_o  = busy_cnt_q;

endmodule

// File: tb/tb_prv664_gscoreboard.sv
// tb/tb_prv664_gscoreboard.sv - directed self-checking bench for prv664_gscoreboard
module tb_prv664_gscoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush;
  logic [1:0]  disp_valid;
  logic [9:0]  disp_rdindex;
  logic [15:0] disp_itag;
  logic [1:0]  cmt_valid, cmt_wren;
  logic [9:0]  cmt_rdindex;
  logic [15:0] cmt_itag;
  logic [19:0] rd_index;

  logic [3:0]   rd_busy_a, rd_busy_b;
  logic [31:0]  rd_itag_a, rd_itag_b;
  logic [31:0]  busy_a, busy_b;
  logic [255:0] id_a, id_b;
  logic [5:0]   cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prv664_gscoreboard #(.ZERO_HW(1), .RNM("ENABLE")) u_dut_a (
    .clk_i(clk), .arst_i(rst), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_rdindex_i(disp_rdindex), .disp_itag_i(disp_itag),
    .cmt_valid_i(cmt_valid), .cmt_wren_i(cmt_wren), .cmt_rdindex_i(cmt_rdindex), .cmt_itag_i(cmt_itag),
    .rd_index_i(rd_index), .rd_busy_o(rd_busy_a), .rd_itag_o(rd_itag_a),
    .busy_flag_o(busy_a), .id_flag_o(id_a), .busy_cnt_o(cnt_a)
  );

  prv664_gscoreboard #(.ZERO_HW(0), .RNM("DISABLE")) u_dut_b (
    .clk_i(clk), .arst_i(rst), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_rdindex_i(disp_rdindex), .disp_itag_i(disp_itag),
    .cmt_valid_i(cmt_valid), .cmt_wren_i(cmt_wren), .cmt_rdindex_i(cmt_rdindex), .cmt_itag_i(cmt_itag),
    .rd_index_i(rd_index), .rd_busy_o(rd_busy_b), .rd_itag_o(rd_itag_b),
    .busy_flag_o(busy_b), .id_flag_o(id_b), .busy_cnt_o(cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; disp_valid = '0; disp_rdindex = '0; disp_itag = '0;
    cmt_valid = '0; cmt_wren = '0; cmt_rdindex = '0; cmt_itag = '0;
  endtask

  task automatic disp(input int s, input int idx, input logic [7:0] tag);
    disp_valid[s] = 1'b1;
    disp_rdindex[s*5 +: 5] = 5'(idx);
    disp_itag[s*8 +: 8] = tag;
  endtask

  task automatic cmt(input int s, input int idx, input logic [7:0] tag, input logic wren);
    cmt_valid[s] = 1'b1;
    cmt_wren[s] = wren;
    cmt_rdindex[s*5 +: 5] = 5'(idx);
    cmt_itag[s*8 +: 8] = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rd_index = '0;
    #2;
    chk("reset_busy", 64'(busy_a), 64'h0);
    chk("reset_cnt", 64'(cnt_a), 64'h0);
    chk("reset_id", 64'(id_a[63:0]), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // async reset mid-run
    disp(0, 3, 8'h03); disp(1, 7, 8'h07);
    tick();
    chk("set_3_7", 64'(busy_a), 64'h88);
    chk("cnt_2", 64'(cnt_a), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy_a), 64'h0);
    chk("arst_cnt", 64'(cnt_a), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // two slots to the same register: youngest itag wins
    disp(0, 5, 8'h11); disp(1, 5, 8'h22);
    tick();
    chk("dual_busy5", 64'(busy_a[5]), 64'd1);
    chk("dual_id5", 64'(id_a[5*8 +: 8]), 64'h22);
    chk("dual_cnt", 64'(cnt_a), 64'd1);
    cmt(0, 5, 8'h11, 1'b1);
    tick();
    chk("stale_cmt", 64'(busy_a[5]), 64'd1);
    cmt(1, 5, 8'h22, 1'b0);
    tick();
    chk("nowren_cmt", 64'(busy_a[5]), 64'd1);
    cmt(1, 5, 8'h22, 1'b1);
    tick();
    chk("match_cmt", 64'(busy_a[5]), 64'd0);
    chk("match_cnt", 64'(cnt_a), 64'd0);
    chk("held_id5", 64'(id_a[5*8 +: 8]), 64'h22);

    // commit bypass on the read port
    disp(0, 9, 8'h40);
    tick();
    rd_index[4:0] = 5'd9;
    #1;
    chk("rd_busy_pre", 64'(rd_busy_a[0]), 64'd1);
    chk("rd_itag", 64'(rd_itag_a[7:0]), 64'h40);
    cmt(0, 9, 8'h41, 1'b1);
    #1;
    chk("rd_stale_nobyp", 64'(rd_busy_a[0]), 64'd1);
    cmt(0, 9, 8'h40, 1'b1);
    #1;
    chk("rd_bypass", 64'(rd_busy_a[0]), 64'd0);
    tick();
    chk("bypass_clear", 64'(busy_a[9]), 64'd0);
    chk("rd_itag_held", 64'(rd_itag_a[7:0]), 64'h40);

    // same-cycle dispatch not visible on reads
    rd_index[9:5] = 5'd14;
    disp(1, 14, 8'h0e);
    #1;
    chk("rd_no_disp_byp", 64'(rd_busy_a[1]), 64'd0);
    tick();
    chk("rd_disp_next", 64'(rd_busy_a[1]), 64'd1);

    // dispatch beats commit on the same register
    disp(0, 12, 8'h01);
    tick();
    cmt(0, 12, 8'h01, 1'b1); disp(1, 12, 8'h02);
    tick();
    chk("coll_busy", 64'(busy_a[12]), 64'd1);
    chk("coll_id", 64'(id_a[12*8 +: 8]), 64'h02);
    chk("coll_cnt", 64'(cnt_a), 64'd2);

    // flush drops same-cycle dispatch
    flush = 1'b1;
    tick();
    chk("flush0_busy", 64'(busy_a), 64'h0);
    disp(0, 1, 8'ha1); disp(1, 2, 8'ha2);
    tick();
    disp(0, 3, 8'ha3); disp(1, 6, 8'ha6);
    tick();
    disp(0, 8, 8'ha8); disp(1, 10, 8'haa);
    tick();
    chk("six_busy", 64'(busy_a), 64'h54e);
    chk("six_cnt", 64'(cnt_a), 64'd6);
    flush = 1'b1; disp(0, 4, 8'h44);
    tick();
    chk("flush_busy", 64'(busy_a), 64'h0);
    chk("flush_cnt", 64'(cnt_a), 64'd0);
    chk("flush_id4", 64'(id_a[4*8 +: 8]), 64'h00);
    chk("flush_id1_held", 64'(id_a[1*8 +: 8]), 64'ha1);

    // register 0 hardwired vs tracked
    rd_index[14:10] = 5'd0;
    disp(0, 0, 8'h55);
    tick();
    chk("z1_busy0", 64'(busy_a[0]), 64'd0);
    chk("z1_cnt", 64'(cnt_a), 64'd0);
    chk("z1_id0", 64'(id_a[7:0]), 64'h00);
    chk("z1_rd", 64'(rd_busy_a[2]), 64'd0);
    chk("z0_busy0", 64'(busy_b[0]), 64'd1);
    chk("z0_cnt", 64'(cnt_b), 64'd1);
    chk("z0_id0", 64'(id_b[7:0]), 64'h55);
    chk("z0_rd", 64'(rd_busy_b[2]), 64'd1);

    // without renaming any commit to the register clears it
    cmt(0, 0, 8'h99, 1'b1);
    tick();
    chk("norn_clear", 64'(busy_b[0]), 64'd0);
    chk("norn_cnt", 64'(cnt_b), 64'd0);

    // full population on the tracked-zero instance
    for (int i = 0; i < 16; i++) begin
      disp(0, 2*i, 8'(i)); disp(1, 2*i+1, 8'(i+16));
      tick();
    end
    chk("full_busy_b", 64'(busy_b), 64'hffffffff);
    chk("full_cnt_b", 64'(cnt_b), 64'd32);
    chk("full_cnt_a", 64'(cnt_a), 64'd31);
    chk("full_id31", 64'(id_b[31*8 +: 8]), 64'h1f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
